// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile
//   Parametrised AXI4-Lite slave register file.
//   - NUM_REGS registers of C_S_AXI_DATA_WIDTH bits each.
//   - RO_MASK bit i makes register i read-only. Reads of a read-only register
//     return the matching sts_i slice, and writes to it answer SLVERR.
//   - Accesses beyond NUM_REGS answer DECERR.
//   - AW and W are captured independently in one-entry holding registers.
//
// Ports
//   s_axi_aclk, s_axi_aresetn      clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*                AXI4-Lite write address / data / response
//   s_axi_ar*/r*                   AXI4-Lite read address / data
//   ctrl_o                         RW register contents, slice i = register i
//   sts_i                          status inputs for RO registers, slice i = register i
//   wr_pulse_o                     one cycle high with the new ctrl_o value after a write commit
//   rd_pulse_o                     one cycle high after a read of register i is accepted
module axi_lite_regfile #(
    parameter int unsigned          C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned          C_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned          NUM_REGS           = 8,
    parameter logic [NUM_REGS-1:0]  RO_MASK            = '0
) (
    input  logic                                   s_axi_aclk,
    input  logic                                   s_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic [2:0]                             s_axi_awprot,
    input  logic                                   s_axi_awvalid,
    output logic                                   s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                                   s_axi_wvalid,
    output logic                                   s_axi_wready,
    output logic [1:0]                             s_axi_bresp,
    output logic                                   s_axi_bvalid,
    input  logic                                   s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic [2:0]                             s_axi_arprot,
    input  logic                                   s_axi_arvalid,
    output logic                                   s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                             s_axi_rresp,
    output logic                                   s_axi_rvalid,
    input  logic                                   s_axi_rready,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_o,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] sts_i,
    output logic [NUM_REGS-1:0]                    wr_pulse_o,
    output logic [NUM_REGS-1:0]                    rd_pulse_o
);

    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned STRB_W   = DW / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
    localparam int unsigned SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    // Write-side holding registers
    logic              aw_full;
    logic [IDX_W-1:0]  aw_idx_q;
    logic              w_full;
    logic [DW-1:0]     w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic              bvalid_q;
    resp_e             bresp_q;
    logic [NUM_REGS-1:0] wr_pulse_q;

    // Read side
    logic              rvalid_q;
    logic [DW-1:0]     rdata_q;
    resp_e             rresp_q;
    logic [NUM_REGS-1:0] rd_pulse_q;

    logic [NUM_REGS*DW-1:0] ctrl_q;

    logic aw_hs, w_hs, ar_hs, commit;
    logic aw_in_range, ar_in_range, ro_hit;
    logic [IDX_W-1:0]    ar_idx;
    logic [NUM_REGS-1:0] aw_dec, wr_sel, rd_sel;
    logic [DW-1:0]       rd_val [NUM_REGS];
    logic [DW-1:0]       rd_mux;

    assign s_axi_awready = !aw_full;
    assign s_axi_wready  = !w_full;
    assign s_axi_arready = !rvalid_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign ctrl_o        = ctrl_q;
    assign wr_pulse_o    = wr_pulse_q;
    assign rd_pulse_o    = rd_pulse_q;

    assign aw_hs  = s_axi_awvalid && !aw_full;
    assign w_hs   = s_axi_wvalid && !w_full;
    assign ar_hs  = s_axi_arvalid && !rvalid_q;
    // A pending response blocks the next commit, while holding registers may still refill.
    assign commit = aw_full && w_full && !bvalid_q;

    assign ar_idx      = s_axi_araddr[ADDR_LSB +: IDX_W];
    assign aw_in_range = (32'(aw_idx_q) < NUM_REGS);
    assign ar_in_range = (32'(ar_idx) < NUM_REGS);
    assign wr_sel      = aw_dec & ~RO_MASK;
    assign ro_hit      = |(aw_dec & RO_MASK);

    // Sink for inputs that the design intentionally ignores
    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awprot, s_axi_arprot,
                             s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0], sts_i};

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        assign aw_dec[g] = (aw_idx_q == IDX_W'(g));
        assign rd_sel[g] = (ar_idx == IDX_W'(g));
        assign rd_val[g] = RO_MASK[g] ? sts_i[g*DW +: DW] : ctrl_q[g*DW +: DW];

        for (genvar b = 0; b < STRB_W; b++) begin : g_byte
            always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
                if (!s_axi_aresetn) begin
                    ctrl_q[g*DW + b*8 +: 8] <= '0;
                end else if (commit && wr_sel[g] && w_strb_q[b]) begin
                    ctrl_q[g*DW + b*8 +: 8] <= w_data_q[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (ar_in_range) begin
            rd_mux = rd_val[ar_idx[SEL_W-1:0]];
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            aw_full    <= 1'b0;
            aw_idx_q   <= '0;
            w_full     <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;

            if (commit) begin
                aw_full <= 1'b0;
            end else if (aw_hs) begin
                aw_full  <= 1'b1;
                aw_idx_q <= s_axi_awaddr[ADDR_LSB +: IDX_W];
            end

            if (commit) begin
                w_full <= 1'b0;
            end else if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end

            if (commit) begin
                bvalid_q <= 1'b1;
                if (!aw_in_range) begin
                    bresp_q <= RESP_DECERR;
                end else if (ro_hit) begin
                    bresp_q <= RESP_SLVERR;
                end else begin
                    bresp_q    <= RESP_OKAY;
                    wr_pulse_q <= wr_sel;
                end
            end else if (s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rd_pulse_q <= '0;
        end else begin
            rd_pulse_q <= '0;
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
                if (ar_in_range) begin
                    rresp_q    <= RESP_OKAY;
                    rd_pulse_q <= rd_sel;
                end else begin
                    rresp_q <= RESP_DECERR;
                end
            end else if (s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb_axi_lite_regfile
//   Directed and randomized bench for axi_lite_regfile (8 x 32-bit, register 7 read-only).
//   Expected values come from a register-array model of the register map.
module tb_axi_lite_regfile;

    localparam int NR = 8;
    localparam logic [NR-1:0] RO = 8'h80;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [5:0]   awaddr = '0, araddr = '0;
    logic [2:0]   awprot = '0, arprot = '0;
    logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [31:0]  wdata = '0, rdata;
    logic [3:0]   wstrb = '0;
    logic [1:0]   bresp, rresp;
    logic [255:0] ctrl, sts;
    logic [7:0]   wr_pulse, rd_pulse;

    int n_assert = 0;
    int n_fail = 0;

    logic [31:0] m_ctrl [NR];
    logic [31:0] m_sts  [NR];

    always #5 clk = ~clk;

    always_comb begin
        sts = '0;
        for (int i = 0; i < NR; i++) sts[i*32 +: 32] = m_sts[i];
    end

    axi_lite_regfile #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(6),
        .NUM_REGS(8),
        .RO_MASK(RO)
    ) dut (
        .s_axi_aclk(clk),       .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr),  .s_axi_awprot(awprot),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata),    .s_axi_wstrb(wstrb),
        .s_axi_wvalid(wvalid),  .s_axi_wready(wready),
        .s_axi_bresp(bresp),    .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr),  .s_axi_arprot(arprot),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata),    .s_axi_rresp(rresp),
        .s_axi_rvalid(rvalid),  .s_axi_rready(rready),
        .ctrl_o(ctrl),          .sts_i(sts),
        .wr_pulse_o(wr_pulse),  .rd_pulse_o(rd_pulse)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int idx_of(input logic [5:0] a);
        return int'(a) / 4;
    endfunction

    function automatic logic [1:0] exp_bresp(input logic [5:0] a);
        int i = idx_of(a);
        if (i >= NR) return 2'b11;
        if (RO[i])   return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [7:0] exp_wpulse(input logic [5:0] a);
        int i = idx_of(a);
        if (i >= NR || RO[i]) return 8'h00;
        return 8'(1 << i);
    endfunction

    function automatic logic [7:0] exp_rpulse(input logic [5:0] a);
        int i = idx_of(a);
        if (i >= NR) return 8'h00;
        return 8'(1 << i);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [5:0] a);
        int i = idx_of(a);
        if (i >= NR) return 32'h0;
        if (RO[i])   return m_sts[i];
        return m_ctrl[i];
    endfunction

    function automatic logic [255:0] exp_ctrl();
        logic [255:0] v = '0;
        for (int i = 0; i < NR; i++) v[i*32 +: 32] = m_ctrl[i];
        return v;
    endfunction

    task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        int i = idx_of(a);
        if (i < NR && !RO[i]) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_ctrl[i][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // ---------------- channel tasks ----------------
    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] er;
        logic [7:0] ep;
        chk("wr_awready_idle", awready, 1);
        chk("wr_wready_idle", wready, 1);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        step();
        awvalid = 0; wvalid = 0;
        chk("wr_bvalid_early", bvalid, 0);
        step();
        er = exp_bresp(a);
        ep = exp_wpulse(a);
        model_write(a, d, s);
        chk("wr_bvalid", bvalid, 1);
        chk("wr_bresp", bresp, er);
        chk("wr_pulse", wr_pulse, ep);
        chk("wr_ctrl", ctrl, exp_ctrl());
        bready = 1;
        step();
        bready = 0;
        chk("wr_bvalid_done", bvalid, 0);
        chk("wr_pulse_done", wr_pulse, 0);
    endtask

    task automatic do_read(input logic [5:0] a, input int hold);
        logic [31:0] ed;
        logic [1:0]  er;
        chk("rd_arready_idle", arready, 1);
        ed = exp_rdata(a);
        er = (idx_of(a) >= NR) ? 2'b11 : 2'b00;
        araddr = a; arvalid = 1;
        step();
        arvalid = 0;
        chk("rd_rvalid", rvalid, 1);
        chk("rd_arready_busy", arready, 0);
        chk("rd_rdata", rdata, ed);
        chk("rd_rresp", rresp, er);
        chk("rd_pulse", rd_pulse, exp_rpulse(a));
        for (int h = 0; h < hold; h++) begin
            step();
            chk("rd_hold_rvalid", rvalid, 1);
            chk("rd_hold_rdata", rdata, ed);
            chk("rd_hold_rresp", rresp, er);
            chk("rd_hold_pulse", rd_pulse, 0);
        end
        rready = 1;
        step();
        rready = 0;
        chk("rd_rvalid_done", rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  a;
        logic [31:0] old;

        for (int i = 0; i < NR; i++) begin m_ctrl[i] = '0; m_sts[i] = 32'h1000_0000 + i; end
        m_sts[7] = 32'hA5A5A5A5;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_arready", arready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ctrl", ctrl, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        chk("rst_rd_pulse", rd_pulse, 0);
        rst_n = 1;
        step();

        // Simultaneous AW+W, then read back
        do_write(6'h08, 32'hDEADBEEF, 4'hF);
        chk("t1_reg2", ctrl[2*32 +: 32], 32'hDEADBEEF);
        do_read(6'h08, 1);

        // W arrives three cycles before AW, partial strobes
        do_write(6'h04, 32'hFFFFFFFF, 4'hF);
        wdata = 32'h12345678; wstrb = 4'h5; wvalid = 1;
        step();
        wvalid = 0;
        chk("t2_wready_low", wready, 0);
        chk("t2_awready_high", awready, 1);
        repeat (2) begin
            step();
            chk("t2_wait_bvalid", bvalid, 0);
            chk("t2_wait_wready", wready, 0);
        end
        awaddr = 6'h04; awvalid = 1;
        step();
        awvalid = 0;
        chk("t2_bvalid_early", bvalid, 0);
        step();
        model_write(6'h04, 32'h12345678, 4'h5);
        chk("t2_bvalid", bvalid, 1);
        chk("t2_bresp", bresp, 2'b00);
        chk("t2_pulse", wr_pulse, 8'h02);
        chk("t2_reg1", ctrl[32 +: 32], 32'hFF34FF78);
        chk("t2_ready_back", {awready, wready}, 2'b11);
        bready = 1; step(); bready = 0;
        chk("t2_bdone", bvalid, 0);

        // Read-only register
        do_write(6'h1C, 32'h55667788, 4'hF);
        do_read(6'h1C, 0);

        // Out of range
        do_write(6'h3C, 32'hCAFEF00D, 4'hF);
        do_read(6'h3C, 2);

        // B backpressure with a second write queued in the holding registers
        awaddr = 6'h10; wdata = 32'hAAAA0001; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        step();
        awvalid = 0; wvalid = 0;
        step();
        model_write(6'h10, 32'hAAAA0001, 4'hF);
        chk("t5_a_bvalid", bvalid, 1);
        chk("t5_a_ctrl", ctrl, exp_ctrl());
        awaddr = 6'h14; wdata = 32'hBBBB0002; wstrb = 4'h3; awvalid = 1; wvalid = 1;
        step();
        awvalid = 0; wvalid = 0;
        chk("t5_awready_full", awready, 0);
        chk("t5_wready_full", wready, 0);
        for (int c = 0; c < 8; c++) begin
            step();
            chk("t5_hold_bvalid", bvalid, 1);
            chk("t5_hold_bresp", bresp, 2'b00);
            chk("t5_hold_ctrl", ctrl, exp_ctrl());
        end
        bready = 1; step(); bready = 0;
        chk("t5_a_done", bvalid, 0);
        step();
        model_write(6'h14, 32'hBBBB0002, 4'h3);
        chk("t5_b_bvalid", bvalid, 1);
        chk("t5_b_pulse", wr_pulse, 8'h20);
        chk("t5_b_ctrl", ctrl, exp_ctrl());
        chk("t5_ready_back", {awready, wready}, 2'b11);
        bready = 1; step(); bready = 0;
        chk("t5_b_done", bvalid, 0);

        // AR on the commit edge returns the pre-write value
        do_write(6'h0C, 32'h11112222, 4'hF);
        old = m_ctrl[3];
        awaddr = 6'h0C; wdata = 32'h33334444; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        step();
        awvalid = 0; wvalid = 0;
        araddr = 6'h0C; arvalid = 1;
        step();
        arvalid = 0;
        model_write(6'h0C, 32'h33334444, 4'hF);
        chk("t8_rdata_old", rdata, old);
        chk("t8_bvalid", bvalid, 1);
        chk("t8_ctrl_new", ctrl, exp_ctrl());
        rready = 1; bready = 1; step(); rready = 0; bready = 0;
        chk("t8_done", {rvalid, bvalid}, 2'b00);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            for (int r = 0; r < NR; r++) m_sts[r] = $urandom;
            a = 6'($urandom_range(0, 63));
            do_write(a, $urandom, 4'($urandom_range(0, 15)));
            a = 6'($urandom_range(0, 63));
            do_read(a, k % 3);
        end

        // Asynchronous reset with AW held and a read response pending
        awaddr = 6'h00; awvalid = 1;
        step();
        awvalid = 0;
        chk("t6_aw_held", awready, 0);
        araddr = 6'h08; arvalid = 1;
        step();
        arvalid = 0;
        chk("t6_rvalid_set", rvalid, 1);
        #3;
        rst_n = 0;
        #1;
        chk("t6_awready", awready, 1);
        chk("t6_wready", wready, 1);
        chk("t6_bvalid", bvalid, 0);
        chk("t6_arready", arready, 1);
        chk("t6_rvalid", rvalid, 0);
        chk("t6_rdata", rdata, 0);
        chk("t6_rresp", rresp, 0);
        chk("t6_ctrl", ctrl, 0);
        chk("t6_pulses", {wr_pulse, rd_pulse}, 16'h0);
        for (int i = 0; i < NR; i++) m_ctrl[i] = '0;
        step();
        rst_n = 1;
        wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1;
        step();
        wvalid = 0;
        repeat (3) begin
            step();
            chk("t6_no_commit", bvalid, 0);
            chk("t6_ctrl_zero", ctrl, exp_ctrl());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_regfile.md
Name: axi_lite_regfile

Overview:
Parametrised AXI4-Lite slave register file, next generation of the fixed four-register template.
- Register count, data width and address width are set by parameters.
- Per-register read-only and status mapping.
- Independent AW/W acceptance.
- SLVERR/DECERR responses.
- Per-register write and read strobes to user logic.

Sits between the PS/interconnect AXI-Lite master and block-level control/status logic.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width; 32 or 64.
C_S_AXI_ADDR_WIDTH, 6, byte address width.
NUM_REGS, 8, number of registers; must be ≤ 2^(C_S_AXI_ADDR_WIDTH-ADDR_LSB).
RO_MASK, 0 (NUM_REGS bits), bit i=1 makes register i read-only; reads return sts_i slice i.

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  reset
s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s_axi_awprot  in  3  ignored
s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
s_axi_wdata  in  C_S_AXI_DATA_WIDTH  write data
s_axi_wstrb  in  C_S_AXI_DATA_WIDTH/8  byte strobes
s_axi_wvalid / s_axi_wready  in / out  1  W handshake
s_axi_bresp  out  2  write response
s_axi_bvalid / s_axi_bready  out / in  1  B handshake
s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s_axi_arprot  in  3  ignored
s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
s_axi_rdata  out  C_S_AXI_DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rvalid / s_axi_rready  out / in  1  R handshake
ctrl_o  out  NUM_REGS*C_S_AXI_DATA_WIDTH  RW register contents; slice i = reg i
sts_i  in  NUM_REGS*C_S_AXI_DATA_WIDTH  status inputs for RO registers; slice i = reg i
wr_pulse_o  out  NUM_REGS  one-cycle pulse on write commit to reg i
rd_pulse_o  out  NUM_REGS  one-cycle pulse on read acceptance of reg i

Behaviour:
Reset and clocking:
- One clock, s_axi_aclk.
- Reset s_axi_aresetn is asynchronous, active-low.

Addressing:
- ADDR_LSB = log2(C_S_AXI_DATA_WIDTH/8).
- Register index = addr[ADDR_LSB +: C_S_AXI_ADDR_WIDTH-ADDR_LSB].

Reset values (all outputs): awready=1, wready=1, bvalid=0, bresp=0, arready=1, rvalid=0, rresp=0, rdata=0, ctrl_o=0, wr_pulse_o=0, rd_pulse_o=0.
- Reset mid-transaction drops all held AW/W/B/R state; no write commits.

Write path:
- AW and W each have a one-entry holding register with a full flag.
  - awready = !aw_full; wready = !w_full.
  - Handshakes are independent; either may arrive first or both in the same cycle.
- Commit occurs on the edge where aw_full && w_full && !bvalid. At commit:
  - clear both full flags; set bvalid.
  - If index ≥ NUM_REGS: bresp=DECERR (2'b11), no update.
  - Else if RO_MASK[i]: bresp=SLVERR (2'b10), no update, no pulse.
  - Else: byte-wise update of ctrl_o slice i for each set wstrb bit, bresp=OKAY, wr_pulse_o[i]=1 for exactly the following cycle (aligned with new ctrl_o value).
- Latency: AW+W accepted at edge N → bvalid high after edge N+1.
- bvalid holds until the bready handshake.
- A new AW/W may be accepted into holding while B is pending; its commit waits until bvalid falls.

Read path:
- arready = !rvalid.
- On AR handshake (edge N):
  - capture data: ctrl_o slice (RW), sts_i slice (RO), or 0 with DECERR (out of range).
  - rvalid=1 after edge N.
  - rd_pulse_o[i]=1 for the cycle after edge N (in-range only), so user logic may clear-on-read.
- rdata/rresp stable while rvalid && !rready.
- Throughput: one read per 2 cycles with rready tied high.

Concurrency:
- Read and write paths are fully independent.
- AR accepted on the same edge as a commit to the same register returns the pre-write value.

Test Plan:
1. Reset, AW+W same cycle addr 0x08, data 0xDEADBEEF, wstrb 0xF -> bvalid 2 cycles after handshake, bresp OKAY, ctrl_o reg2=0xDEADBEEF, wr_pulse_o=0x04 for one cycle; read 0x08 returns 0xDEADBEEF, rd_pulse_o=0x04.
2. W issued 3 cycles before AW (addr 0x04, data 0x12345678, wstrb 0x5) on reg1 preloaded 0xFFFFFFFF -> wready drops after W handshake, awready stays 1; commit after AW; reg1=0xFF34FF78.
3. RO_MASK=0x80, sts_i reg7=0xA5A5A5A5; write 0x1C -> bresp SLVERR, no wr_pulse; read 0x1C -> 0xA5A5A5A5 OKAY.
4. NUM_REGS=8, addr width 6: write/read addr 0x3C -> bresp/rresp DECERR, rdata 0, no pulses, ctrl_o unchanged.
5. bready held low 10 cycles after write A; second AW/W issued -> accepted into holding, awready/wready then 0, bvalid/bresp of A stable; second commit after B of A handshakes.
6. Assert s_axi_aresetn low asynchronously with AW held and rvalid high -> all outputs at reset values immediately, no commit after release.
